// File: rtl/maxpool_flatten_engine_pkg.sv
// Shared definitions for the layer-1/layer-2 pooling stage: memory select codes,
// default widths and the FSM state encoding.
package maxpool_flatten_engine_pkg;

    // Feature-map samples are Q4.16 fixed point, non-negative after layer-0 ReLU,
    // so an unsigned compare orders them correctly.
    localparam int IN_W_DEFAULT = 64;
    localparam int DW_DEFAULT   = 20;
    localparam int AW_DEFAULT   = 12;

    localparam logic [2:0] CSEL_NONE = 3'd0;
    localparam logic [2:0] CSEL_L0K0 = 3'd1;
    localparam logic [2:0] CSEL_L0K1 = 3'd2;
    localparam logic [2:0] CSEL_L1K0 = 3'd3;
    localparam logic [2:0] CSEL_L1K1 = 3'd4;
    localparam logic [2:0] CSEL_L2   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_DRN,
        S_WL1,
        S_WL2,
        S_NXT,
        S_FIN
    } state_t;

endpackage

// File: rtl/maxpool_flatten_engine_pool_max_reg.sv
// Running maximum over the four samples of one 2x2 pooling window.
module pool_max_reg #(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] max
);

    // The first sample overwrites the register; later samples replace it only when
    // strictly larger, so ties keep the earlier sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max <= '0;
        end else if (load) begin
            max <= din;
        end else if (en && (din > max)) begin
            max <= din;
        end
    end

endmodule

// File: rtl/maxpool_flatten_engine.sv
// 2x2 stride-2 max-pooling of both layer-0 maps into the layer-1 maps and the
// kernel-interleaved flatten memory.
module maxpool_flatten_engine
    import maxpool_flatten_engine_pkg::*;
#(
    parameter int IN_W = IN_W_DEFAULT,
    parameter int DW   = DW_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int LOG_W = $clog2(IN_W);
    localparam int PB    = LOG_W - 1;

    state_t        state, state_next;
    logic          k;
    logic [PB-1:0] pr, pc;
    logic          max_load, max_en;
    logic [DW-1:0] max_val;
    logic          win_row, win_col;

    pool_max_reg #(.DW(DW)) u_max (
        .clk   (clk),
        .reset (reset),
        .load  (max_load),
        .en    (max_en),
        .din   (cdata_rd),
        .max   (max_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Kernel is the outer loop, pooled column the inner; everything rewinds on a new start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k  <= 1'b0;
            pr <= '0;
            pc <= '0;
        end else if ((state == S_IDLE) && start) begin
            k  <= 1'b0;
            pr <= '0;
            pc <= '0;
        end else if (state == S_NXT) begin
            if (pc == '1) begin
                pc <= '0;
                if (pr == '1) begin
                    pr <= '0;
                    k  <= ~k;
                end else begin
                    pr <= pr + 1'b1;
                end
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RD0;
            S_RD0:  state_next = S_RD1;
            S_RD1:  state_next = S_RD2;
            S_RD2:  state_next = S_RD3;
            S_RD3:  state_next = S_DRN;
            S_DRN:  state_next = S_WL1;
            S_WL1:  state_next = S_WL2;
            S_WL2:  state_next = S_NXT;
            S_NXT:  state_next = ((pc == '1) && (pr == '1) && k) ? S_FIN : S_RD0;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Read data lags crd by one cycle, so the max register works one state behind the reads.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_FIN);
        crd      = 1'b0;
        cwr      = 1'b0;
        csel     = CSEL_NONE;
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        win_row  = 1'b0;
        win_col  = 1'b0;
        max_load = (state == S_RD1);
        max_en   = (state == S_RD2) || (state == S_RD3) || (state == S_DRN);
        case (state)
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                win_row  = (state == S_RD2) || (state == S_RD3);
                win_col  = (state == S_RD1) || (state == S_RD3);
                crd      = 1'b1;
                csel     = k ? CSEL_L0K1 : CSEL_L0K0;
                caddr_rd = AW'({pr, win_row, pc, win_col});
            end
            S_WL1: begin
                cwr      = 1'b1;
                csel     = k ? CSEL_L1K1 : CSEL_L1K0;
                caddr_wr = AW'({pr, pc});
                cdata_wr = max_val;
            end
            S_WL2: begin
                cwr      = 1'b1;
                csel     = CSEL_L2;
                caddr_wr = AW'({pr, pc, k});
                cdata_wr = max_val;
            end
            default: begin
                crd = 1'b0;
            end
        endcase
    end

endmodule
